// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: round-robin, packet-atomic sharing of the outbound FIFO write port
// with a stall watchdog that aborts an owner whose stream stops mid-packet.
module ft245_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 out_fifo_wr,
  output logic [7:0]           out_fifo_data,
  input  logic                 out_fifo_full,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     pkt_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
  state_t state, state_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [IW-1:0] last_grant, last_nx, owner, pick, idx;
  logic [TW-1:0] idle_cnt, idle_nx;
  logic stall, done, abort;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last_grant  <= last_nx;
      idle_cnt    <= idle_nx;
      timeout_err <= abort;
      pkt_count   <= pkt_count + CNT_W'(done);
    end
  end
  // Owner index from the one-hot grant, and the round-robin pick starting after last_grant.
  always_comb begin
    owner = '0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) owner = IW'(i);
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_nx = IDLE;
    grant_nx = '0;
    last_nx  = last_grant;
    idle_nx  = '0;
    stall    = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    if (state == IDLE && |req_valid) begin
      state_nx = XFER;
      grant_nx = NUM_REQ'(1) << pick;
    end else if (state == XFER) begin
      stall    = !(|(req_valid & grant));
      done     = out_fifo_wr && |(req_last & grant);
      abort    = stall && idle_cnt == TW'(TIMEOUT - 1);
      state_nx = (done || abort) ? IDLE : XFER;
      grant_nx = (done || abort) ? '0 : grant;
      last_nx  = (done || abort) ? owner : last_grant;
      // Backpressure with valid high leaves the watchdog frozen.
      idle_nx  = (out_fifo_wr || abort) ? '0 : stall ? idle_cnt + 1'b1 : idle_cnt;
    end
  end
  always_comb begin
    req_ready     = (state == XFER && !out_fifo_full) ? grant : '0;
    out_fifo_wr   = |(req_valid & req_ready);
    out_fifo_data = req_data[{owner, 3'b000} +: 8];
  end
endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// tb_ft245_tx_arbiter: directed packets through a queue-fed driver, checked each cycle
// against an integer-level model of the arbitration rules plus literal expectations.
module tb_ft245_tx_arbiter;
  localparam int N = 2, TO = 8, CW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid, req_last, req_ready, grant;
  logic [N*8-1:0] req_data;
  logic out_fifo_wr, out_fifo_full, timeout_err;
  logic [7:0] out_fifo_data;
  logic [CW-1:0] pkt_count;
  int checks = 0, errors = 0;
  logic [8:0] q [N][$];
  logic [7:0] wlog [$], ex [$];
  int wr_seen, terr_seen;
  int m_own = -1, m_last = N - 1, m_idle = 0, m_cnt = 0;
  bit m_terr = 0, t_abort, found;
  logic [N-1:0] e_grant, e_ready;
  bit e_wr;

  ft245_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .out_fifo_wr(out_fifo_wr), .out_fifo_data(out_fifo_data),
    .out_fifo_full(out_fifo_full), .timeout_err(timeout_err), .pkt_count(pkt_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is an index (-1 = nobody), stall counted in idle cycles.
  always @(negedge clk) begin
    if (!rst) begin
      m_own = -1; m_last = N - 1; m_idle = 0; m_cnt = 0; m_terr = 0;
      chk("rst_grant", grant, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_wr", out_fifo_wr, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_cnt", pkt_count, 0);
    end else begin
      e_grant = (m_own < 0) ? '0 : N'(1) << m_own;
      e_ready = (m_own >= 0 && !out_fifo_full) ? e_grant : '0;
      e_wr = |(e_ready & req_valid);
      chk("m_grant", grant, e_grant);
      chk("m_ready", req_ready, e_ready);
      chk("m_wr", out_fifo_wr, e_wr);
      chk("m_terr", timeout_err, m_terr);
      chk("m_cnt", pkt_count, m_cnt);
      if (e_wr) chk("m_data", out_fifo_data, req_data[m_own*8 +: 8]);
      t_abort = 0;
      if (m_own < 0) begin
        found = 0;
        for (int k = 1; k <= N; k++)
          if (!found && req_valid[(m_last + k) % N]) begin
            found = 1;
            m_own = (m_last + k) % N;
          end
        m_idle = 0;
      end else if (e_wr) begin
        if (req_last[m_own]) begin
          m_last = m_own;
          m_cnt = (m_cnt + 1) % (1 << CW);
          m_own = -1;
        end
        m_idle = 0;
      end else if (!req_valid[m_own]) begin
        m_idle++;
        if (m_idle == TO) begin
          t_abort = 1;
          m_last = m_own;
          m_own = -1;
          m_idle = 0;
        end
      end
      m_terr = t_abort;
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = q[i].size() > 0;
      req_last[i] = (q[i].size() > 0) ? q[i][0][8] : 1'b0;
      req_data[i*8 +: 8] = (q[i].size() > 0) ? q[i][0][7:0] : 8'h00;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    if (out_fifo_wr) begin
      wlog.push_back(out_fifo_data);
      wr_seen++;
    end
    if (timeout_err) terr_seen++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) void'(q[i].pop_front());
    drive();
  endtask

  task automatic pkt(input int r, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) q[r].push_back({i == n - 1, first + 8'(i)});
    drive();
  endtask

  task automatic expect_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) ex.push_back(first + 8'(i));
  endtask

  task automatic run_done(input int bound);
    int n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0 || grant != 0) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_in_bound", n < bound, 1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, wlog.size(), ex.size());
    for (int i = 0; i < ex.size() && i < wlog.size(); i++) chk(name, wlog[i], ex[i]);
    wlog.delete();
    ex.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    out_fifo_full = 1'b0;
    drive();
    #2 rst = 1'b0;
    #2;
    chk("reset_grant", grant, 0);
    chk("reset_cnt", pkt_count, 0);
    cycle();
    rst = 1'b1;
    // 1: single 4-byte packet from R0
    pkt(0, 8'hA1, 4);
    expect_seq(8'hA1, 4);
    cycle();
    chk("t1_grant", grant, 2'b01);
    chk("t1_first_wr", out_fifo_wr, 1);
    chk("t1_first_data", out_fifo_data, 8'hA1);
    run_done(50);
    check_log("t1_log");
    chk("t1_cnt", pkt_count, 1);
    // 2: both requesters busy from reset, rotation R0,R1,R0
    #2 rst = 1'b0;
    cycle();
    rst = 1'b1;
    wlog.delete();
    pkt(0, 8'hB0, 2);
    pkt(0, 8'hB2, 2);
    pkt(1, 8'hC0, 2);
    expect_seq(8'hB0, 2);
    expect_seq(8'hC0, 2);
    expect_seq(8'hB2, 2);
    run_done(50);
    check_log("t2_log");
    chk("t2_cnt", pkt_count, 3);
    // 3: FIFO full for 50 cycles mid-packet never times out
    pkt(1, 8'hD0, 4);
    expect_seq(8'hD0, 4);
    cycle();
    chk("t3_grant", grant, 2'b10);
    cycle();
    out_fifo_full = 1'b1;
    wr_seen = 0;
    terr_seen = 0;
    repeat (50) cycle();
    chk("t3_ready_full", req_ready, 0);
    chk("t3_writes_full", wr_seen, 0);
    chk("t3_terr_full", terr_seen, 0);
    chk("t3_grant_held", grant, 2'b10);
    out_fifo_full = 1'b0;
    run_done(50);
    check_log("t3_log");
    chk("t3_cnt", pkt_count, 4);
    // 4: stalled owner aborted after TO idle cycles, pending R1 next
    q[0].push_back(9'h0E0);
    pkt(1, 8'hF0, 1);
    ex.push_back(8'hE0);
    ex.push_back(8'hF0);
    cycle();
    chk("t4_grant", grant, 2'b01);
    cycle();
    repeat (TO - 1) cycle();
    chk("t4_no_early_terr", timeout_err, 0);
    chk("t4_still_owned", grant, 2'b01);
    cycle();
    chk("t4_terr", timeout_err, 1);
    chk("t4_grant_clear", grant, 0);
    chk("t4_cnt_kept", pkt_count, 4);
    cycle();
    chk("t4_terr_pulse", timeout_err, 0);
    chk("t4_r1_grant", grant, 2'b10);
    run_done(50);
    check_log("t4_log");
    chk("t4_cnt", pkt_count, 5);
    // 5: asynchronous reset mid-packet, then R0 wins first
    pkt(1, 8'h50, 3);
    cycle();
    chk("t5_grant", grant, 2'b10);
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("t5_async_grant", grant, 0);
    chk("t5_async_ready", req_ready, 0);
    chk("t5_async_wr", out_fifo_wr, 0);
    wlog.delete();
    pkt(0, 8'h60, 1);
    cycle();
    rst = 1'b1;
    ex.push_back(8'h60);
    expect_seq(8'h51, 2);
    cycle();
    chk("t5_first_grant", grant, 2'b01);
    run_done(50);
    check_log("t5_log");
    chk("t5_cnt", pkt_count, 2);
    // 6: packet counter wraps
    for (int i = 0; i < 13; i++) pkt(0, 8'(i), 1);
    run_done(100);
    chk("t6_cnt_max", pkt_count, 4'hF);
    pkt(0, 8'hEE, 1);
    run_done(20);
    chk("t6_cnt_wrap", pkt_count, 4'h0);
    chk("t6_terr", timeout_err, 0);
    chk("t6_grant", grant, 0);
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
